decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset; assertion takes effect immediately, deassertion is sampled on the clk rising edge.
REQ-003 flush  input  1  synchronous pipeline flush; discards all buffered instructions.
REQ-004 in_valid  input  1  fetch presents an instruction.
REQ-005 in_ready  output  1  stage can accept; an instruction is transferred on a clk edge where in_valid and in_ready are both 1.
REQ-006 instr  input  32  instruction word.
REQ-007 in_pc  input  32  PC of instr.
REQ-008 out_valid  output  1  decoded bundle valid toward execute.
REQ-009 out_ready  input  1  execute accepts the bundle; a pop occurs on a clk edge where out_valid and out_ready are both 1.
REQ-010 operand_1  output  5  rs field.
REQ-011 operand_2  output  5  rt field.
REQ-012 gpr_destination_address  output  32  destination register or jump target.
REQ-013 alu_control  output  4  operation select.
REQ-014 reg_write  output  1  destination write enable.
REQ-015 immediate_value  output  16  imm field.
REQ-016 out_pc  output  32  PC of the bundle.
REQ-017 illegal  output  1  bundle holds an unrecognised opcode.
REQ-018 illegal_count  output  8  saturating count of illegal instructions accepted.

Function
REQ-019 Field slicing shall be: opcode=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm=[15:0], target=[25:0].
REQ-020 Opcode 6'h00 with funct 6'h20 shall decode as follows: alu_control=4'b0001, gpr_destination_address={27'b0,rd}, reg_write=1.
REQ-021 Opcode 6'h08 shall decode as follows: alu_control=4'b0010, gpr_destination_address={27'b0,rt}, reg_write=1.
REQ-022 Opcode 6'h02 shall decode as follows: alu_control=4'b0011, gpr_destination_address={6'b0,target}, reg_write=1.
REQ-023 Any other opcode/funct combination shall decode as follows: alu_control=4'b0000, reg_write=0, illegal=1, gpr_destination_address=0.
REQ-024 operand_1, operand_2, immediate_value and out_pc shall always carry rs, rt, imm and in_pc of the captured instruction, regardless of decode result.
REQ-025 Decode shall be registered with a latency of 1 cycle: an instruction accepted at edge N shall drive out_valid=1 after edge N.
REQ-026 The stage shall contain a 2-entry buffer (head drives the outputs, skid behind it) with states EMPTY, HALF and FULL.
REQ-027 EMPTY: on accept, the stage shall go to HALF and load the head.
REQ-028 HALF, accept without pop: the stage shall go to FULL and load the skid.
REQ-029 HALF, pop without accept: the stage shall go to EMPTY.
REQ-030 HALF, simultaneous accept and pop: the stage shall stay in HALF and load the head with the new instruction.
REQ-031 FULL, pop: the stage shall go to HALF and move the skid into the head; accept is impossible in FULL.
REQ-032 in_ready shall be a registered output equal to 1 in EMPTY and HALF and 0 in FULL.
REQ-033 out_valid shall be 1 in HALF and FULL and 0 in EMPTY.
REQ-034 While out_valid=1 and out_ready=0, all bundle outputs shall hold stable.
REQ-035 Instructions shall leave the stage in acceptance order; none shall be dropped or duplicated.
REQ-036 flush shall have priority over accept and pop: next state EMPTY, and any same-cycle accept shall be discarded.
REQ-037 illegal_count shall increment by 1 on each accepted illegal instruction, saturate at 8'hFF, and not be cleared by flush.

Reset
REQ-038 While rst_n=0, the stage shall be in EMPTY, with out_valid=0, in_ready=1, illegal_count=0, and all bundle outputs (operand_1, operand_2, gpr_destination_address, alu_control, reg_write, immediate_value, out_pc, illegal) equal to 0.
REQ-039 Reset asserted mid-transfer shall discard both buffer entries; the first accept after release shall appear one cycle later.

Verification
REQ-040 Scenario: instr=32'h0022_1820 (add rd=3, rs=1, rt=2), in_pc=32'h100, out_ready=1 -> next cycle out_valid=1, alu_control=0001, operand_1=1, operand_2=2, gpr_destination_address=3, reg_write=1, out_pc=32'h100.
REQ-041 Scenario: instr=32'h2025_1212 (op 08, rs=1, rt=5) -> alu_control=0010, gpr_destination_address=5, immediate_value=16'h1212; instr=32'h0800_0021 (op 02) -> alu_control=0011, gpr_destination_address=32'h21.
REQ-042 Scenario: out_ready=0, three back-to-back in_valid cycles -> first two accepted; in_ready=0 after the second accept; outputs hold the first instruction; after out_ready=1, bundles pop in order and the third instruction is accepted once in_ready returns to 1.
REQ-043 Scenario: FULL, then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed instructions never appear.
REQ-044 Scenario: 260 accepted instructions with opcode 6'h3F -> illegal=1 on each bundle, alu_control=0, reg_write=0, illegal_count=8'hFF; a subsequent flush leaves illegal_count=8'hFF.
REQ-045 Scenario: rst_n pulsed low asynchronously while in HALF -> out_valid=0 and illegal_count=0 before the next clk edge.

Source files
------------

// File: rtl/decode_stage_if.sv
// Fetch-to-execute handshake bundle for the decode stage.
// slave is the stage side; master is the side that drives fetch and execute.
interface decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  operand_1;
  logic [4:0]  operand_2;
  logic [31:0] gpr_destination_address;
  logic [3:0]  alu_control;
  logic        reg_write;
  logic [15:0] immediate_value;
  logic [31:0] out_pc;
  logic        illegal;
  logic [7:0]  illegal_count;

  modport slave (
    input  in_valid, instr, in_pc, out_ready,
    output in_ready, out_valid, operand_1, operand_2, gpr_destination_address,
           alu_control, reg_write, immediate_value, out_pc, illegal, illegal_count
  );

  modport master (
    output in_valid, instr, in_pc, out_ready,
    input  in_ready, out_valid, operand_1, operand_2, gpr_destination_address,
           alu_control, reg_write, immediate_value, out_pc, illegal, illegal_count
  );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode stage: combinational field decode captured into a
// two-entry head/skid buffer with registered valid/ready handshakes.
module decode_stage (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  decode_stage_if.slave  bus
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ALU_W  = 4;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned CNT_W  = 8;

  localparam logic [5:0]       OP_RTYPE  = 6'h00;
  localparam logic [5:0]       OP_ADDI   = 6'h08;
  localparam logic [5:0]       OP_JUMP   = 6'h02;
  localparam logic [5:0]       FN_ADD    = 6'h20;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef struct packed {
    logic [REG_W-1:0]  operand_1;
    logic [REG_W-1:0]  operand_2;
    logic [DATA_W-1:0] gpr_dst;
    logic [ALU_W-1:0]  alu_control;
    logic              reg_write;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] pc;
    logic              illegal;
  } bundle_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HALF  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  bundle_t          r_head;
  bundle_t          r_skid;
  bundle_t          w_dec;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_illegal_count;
  logic             w_accept;
  logic             w_pop;
  logic             w_load_head_in;
  logic             w_load_head_skid;
  logic             w_load_skid;

  // Field slicing and opcode decode; pass-through fields are kept even when illegal.
  function automatic bundle_t decode(input logic [DATA_W-1:0] ins,
                                     input logic [DATA_W-1:0] pc);
    bundle_t b;
    b             = '0;
    b.operand_1   = ins[25:21];
    b.operand_2   = ins[20:16];
    b.imm         = ins[15:0];
    b.pc          = pc;
    if (ins[31:26] == OP_RTYPE && ins[5:0] == FN_ADD) begin
      b.alu_control = 4'b0001;
      b.gpr_dst     = {27'b0, ins[15:11]};
      b.reg_write   = 1'b1;
    end else if (ins[31:26] == OP_ADDI) begin
      b.alu_control = 4'b0010;
      b.gpr_dst     = {27'b0, ins[20:16]};
      b.reg_write   = 1'b1;
    end else if (ins[31:26] == OP_JUMP) begin
      b.alu_control = 4'b0011;
      b.gpr_dst     = {6'b0, ins[25:0]};
      b.reg_write   = 1'b1;
    end else begin
      b.illegal     = 1'b1;
    end
    return b;
  endfunction

  assign w_dec    = decode(bus.instr, bus.in_pc);
  assign w_accept = bus.in_valid & r_in_ready & ~flush;
  assign w_pop    = r_out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Next state and buffer load selects; flush overrides any accept or pop.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_head_in   = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_state_nxt    = S_HALF;
            w_load_head_in = 1'b1;
          end
        end
        S_HALF: begin
          case ({w_accept, w_pop})
            2'b10: begin
              w_state_nxt = S_FULL;
              w_load_skid = 1'b1;
            end
            2'b01: w_state_nxt = S_EMPTY;
            2'b11: w_load_head_in = 1'b1;
            default: w_state_nxt = S_HALF;
          endcase
        end
        S_FULL: begin
          if (w_pop) begin
            w_state_nxt      = S_HALF;
            w_load_head_skid = 1'b1;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // Handshake flags are registered from the next state so they track the buffer fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt != S_FULL);
      r_out_valid <= (w_state_nxt != S_EMPTY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_head_in)        r_head <= w_dec;
      else if (w_load_head_skid) r_head <= r_skid;
      if (w_load_skid)           r_skid <= w_dec;
    end
  end

  // Illegal counter survives flush and sticks at its maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal_count <= '0;
    end else if (w_accept && w_dec.illegal && r_illegal_count != CNT_MAX) begin
      r_illegal_count <= r_illegal_count + CNT_W'(1);
    end
  end

  assign bus.in_ready                = r_in_ready;
  assign bus.out_valid               = r_out_valid;
  assign bus.operand_1               = r_head.operand_1;
  assign bus.operand_2               = r_head.operand_2;
  assign bus.gpr_destination_address = r_head.gpr_dst;
  assign bus.alu_control             = r_head.alu_control;
  assign bus.reg_write               = r_head.reg_write;
  assign bus.immediate_value         = r_head.imm;
  assign bus.out_pc                  = r_head.pc;
  assign bus.illegal                 = r_head.illegal;
  assign bus.illegal_count           = r_illegal_count;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: the driver tags each instruction with its
// hand-computed bundle, the monitor tracks buffer occupancy and checks every output.
module tb_decode_stage;

  typedef struct packed {
    logic [4:0]  operand_1;
    logic [4:0]  operand_2;
    logic [31:0] gpr_dst;
    logic [3:0]  alu_control;
    logic        reg_write;
    logic [15:0] imm;
    logic [31:0] pc;
    logic        illegal;
  } exp_t;

  logic clk;
  logic rst_n;
  logic flush;
  exp_t cur_exp;
  exp_t q[$];
  logic [7:0] m_cnt;
  int checks;
  int errors;

  decode_stage_if bus();

  decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] o1, input logic [4:0] o2,
                              input logic [31:0] d, input logic [3:0] a, input logic rw,
                              input logic [15:0] im, input logic [31:0] pc, input logic il);
    exp_t e;
    e = '{operand_1: o1, operand_2: o2, gpr_dst: d, alu_control: a, reg_write: rw,
          imm: im, pc: pc, illegal: il};
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t e;
    e = '{operand_1: bus.operand_1, operand_2: bus.operand_2,
          gpr_dst: bus.gpr_destination_address, alu_control: bus.alu_control,
          reg_write: bus.reg_write, imm: bus.immediate_value, pc: bus.out_pc,
          illegal: bus.illegal};
    return e;
  endfunction

  // Monitor: checks occupancy-derived handshakes, the head bundle and the illegal count.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_cnt = 8'h00;
    end else begin
      chk("out_valid", 128'(bus.out_valid), 128'(q.size() != 0));
      chk("in_ready", 128'(bus.in_ready), 128'(q.size() < 2));
      chk("illegal_count", 128'(bus.illegal_count), 128'(m_cnt));
      if (flush) begin
        q.delete();
      end else begin
        if (bus.out_valid && q.size() > 0) begin
          chk("bundle", 128'(actual()), 128'(q[0]));
          if (bus.out_ready) void'(q.pop_front());
        end
        if (bus.in_valid && bus.in_ready) begin
          q.push_back(cur_exp);
          if (cur_exp.illegal && m_cnt != 8'hFF) m_cnt = m_cnt + 8'h01;
        end
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input exp_t e);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.instr    = ins;
    bus.in_pc    = pc;
    cur_exp      = e;
    while (!done) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        chk("accept_timeout", 128'(n), 128'(0));
        done = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 128'(q.size()), 128'(0));
  endtask

  localparam logic [31:0] I_ADD  = 32'h0022_1820;
  localparam logic [31:0] I_ADDI = 32'h2025_1212;
  localparam logic [31:0] I_JMP  = 32'h0800_0021;
  localparam logic [31:0] I_BADF = 32'h0022_1822;

  initial begin
    checks = 0;
    errors = 0;
    m_cnt  = 8'h00;
    rst_n  = 1'b0;
    flush  = 1'b0;
    cur_exp = '0;
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_count", 128'(bus.illegal_count), 128'(0));
    chk("rst_bundle", 128'(actual()), 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Each decode class, streaming with out_ready held high
    send(I_ADD,  32'h100, mk(5'd1, 5'd2, 32'd3,    4'b0001, 1'b1, 16'h1820, 32'h100, 1'b0));
    send(I_ADDI, 32'h104, mk(5'd1, 5'd5, 32'd5,    4'b0010, 1'b1, 16'h1212, 32'h104, 1'b0));
    send(I_JMP,  32'h108, mk(5'd0, 5'd0, 32'h21,   4'b0011, 1'b1, 16'h0021, 32'h108, 1'b0));
    send(I_BADF, 32'h10C, mk(5'd1, 5'd2, 32'd0,    4'b0000, 1'b0, 16'h1822, 32'h10C, 1'b1));
    drain();

    // Backpressure: two accepted, third waits until the consumer resumes
    bus.out_ready = 1'b0;
    fork
      begin
        send(I_ADD,  32'h200, mk(5'd1, 5'd2, 32'd3,  4'b0001, 1'b1, 16'h1820, 32'h200, 1'b0));
        send(I_ADDI, 32'h204, mk(5'd1, 5'd5, 32'd5,  4'b0010, 1'b1, 16'h1212, 32'h204, 1'b0));
        send(I_JMP,  32'h208, mk(5'd0, 5'd0, 32'h21, 4'b0011, 1'b1, 16'h0021, 32'h208, 1'b0));
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("stall_in_ready", 128'(bus.in_ready), 128'(0));
        chk("stall_head_pc", 128'(bus.out_pc), 128'(32'h200));
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Flush while FULL with a competing accept
    bus.out_ready = 1'b0;
    send(I_ADD,  32'h300, mk(5'd1, 5'd2, 32'd3, 4'b0001, 1'b1, 16'h1820, 32'h300, 1'b0));
    send(I_ADDI, 32'h304, mk(5'd1, 5'd5, 32'd5, 4'b0010, 1'b1, 16'h1212, 32'h304, 1'b0));
    bus.in_valid = 1'b1;
    bus.instr    = I_JMP;
    bus.in_pc    = 32'h308;
    cur_exp      = mk(5'd0, 5'd0, 32'h21, 4'b0011, 1'b1, 16'h0021, 32'h308, 1'b0);
    flush        = 1'b1;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", 128'(bus.out_valid), 128'(0));
    chk("flush_in_ready", 128'(bus.in_ready), 128'(1));
    bus.out_ready = 1'b1;
    send(I_ADD, 32'h310, mk(5'd1, 5'd2, 32'd3, 4'b0001, 1'b1, 16'h1820, 32'h310, 1'b0));
    drain();

    // Illegal counter saturation, then flush must not clear it
    for (int i = 0; i < 260; i++) begin
      send(32'hFC00_0000 | 32'(i), 32'h1000 + 32'(4 * i),
           mk(5'd0, 5'd0, 32'd0, 4'b0000, 1'b0, 16'(i), 32'h1000 + 32'(4 * i), 1'b1));
    end
    drain();
    chk("sat_count", 128'(bus.illegal_count), 128'(8'hFF));
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("sat_after_flush", 128'(bus.illegal_count), 128'(8'hFF));

    // Asynchronous reset pulse while HALF
    bus.out_ready = 1'b0;
    send(I_ADD, 32'h400, mk(5'd1, 5'd2, 32'd3, 4'b0001, 1'b1, 16'h1820, 32'h400, 1'b0));
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("arst_count", 128'(bus.illegal_count), 128'(0));
    chk("arst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("arst_bundle", 128'(actual()), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send(I_ADDI, 32'h500, mk(5'd1, 5'd5, 32'd5, 4'b0010, 1'b1, 16'h1212, 32'h500, 1'b0));
    chk("post_reset_valid", 128'(bus.out_valid), 128'(1));
    chk("post_reset_pc", 128'(bus.out_pc), 128'(32'h500));
    drain();
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
